// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: SRAM read port, redirect input and decode handshake.
// The master side is the fetch unit; the slave side is the SRAM + decode environment.
interface ifu_fetch_if;
  logic        sram_enable_o;
  logic [31:0] sram_addr_o;
  logic [31:0] sram_data_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  modport master (
    output sram_enable_o, sram_addr_o, inst_valid_o, inst_o, inst_pc_o,
    input  sram_data_i, redirect_valid_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  sram_enable_o, sram_addr_o, inst_valid_o, inst_o, inst_pc_o,
    output sram_data_i, redirect_valid_i, redirect_pc_i, inst_ready_i
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues 1-cycle-latency SRAM reads,
// buffers returned words in a 2-entry FIFO and hands them to decode.
// Redirects flush the buffer and kill the read already in flight.
// Optional macro IFU_BYPASS_EN: a live response arriving while the buffer
// is empty is presented to decode in the same cycle (1-cycle latency).

// Overflow watchdog: a push into a full buffer means the issue rule is broken.
module ifu_fetch_chk #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic       i_clk,
  input logic       i_rst,
  input logic       i_push,
  input logic [1:0] i_count
);
  localparam logic [1:0] FULL_C = 2'(FIFO_DEPTH);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && (i_count == FULL_C)));
endmodule

module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  ifu_fetch_if.master bus
);
  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_inflight;
  logic        r_kill;
  logic [31:0] r_mem_data [2];
  logic [31:0] r_mem_pc   [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_head_valid;
  logic        w_resp_live;
  logic        w_bypass;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_pop;
  logic        w_fifo_pop;
  logic        w_push;
  logic [2:0]  w_occ;
  logic        w_issue;
  logic        w_unused_ok;

  // Redirect targets are word aligned; the low bits are deliberately dropped.
  assign w_unused_ok = &{1'b0, bus.redirect_pc_i[1:0]};

  // Head selection, handshake, push/pop and issue decisions for this cycle.
  always_comb begin
    w_head_valid = (r_count != 2'd0);
    w_resp_live  = r_inflight & ~r_kill & ~bus.redirect_valid_i;
`ifdef IFU_BYPASS_EN
    w_bypass     = ~w_head_valid & w_resp_live;
`else
    w_bypass     = 1'b0;
`endif
    if (w_head_valid) begin
      w_valid   = 1'b1;
      w_inst    = r_mem_data[r_rd_ptr];
      w_inst_pc = r_mem_pc[r_rd_ptr];
    end else if (w_bypass) begin
      w_valid   = 1'b1;
      w_inst    = bus.sram_data_i;
      w_inst_pc = r_req_pc;
    end else begin
      w_valid   = 1'b0;
      w_inst    = 32'h0000_0000;
      w_inst_pc = 32'h0000_0000;
    end
    w_pop      = w_valid & bus.inst_ready_i;
    w_fifo_pop = w_pop & w_head_valid;
    // A bypassed word taken by decode this cycle never enters the buffer.
    w_push     = w_resp_live & ~(w_bypass & bus.inst_ready_i);
    // Projected occupancy: buffered words minus the one leaving, plus the read in flight.
    w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue    = (r_state == ST_RUN) & ~bus.redirect_valid_i & (w_occ < DEPTH_C);
  end

  assign bus.sram_enable_o = w_issue;
  assign bus.sram_addr_o   = w_issue ? r_pc : 32'h0000_0000;
  assign bus.inst_valid_o  = w_valid;
  assign bus.inst_o        = w_inst;
  assign bus.inst_pc_o     = w_inst_pc;

  // Boot sequencing: one idle cycle after reset, then fetch forever.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_BOOT;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  // PC, in-flight tracking and kill of the read outstanding at a redirect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= 32'h0000_0000;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= bus.redirect_valid_i & r_inflight;
      if (bus.redirect_valid_i) begin
        r_pc <= {bus.redirect_pc_i[31:2], 2'b00};
      end else if (w_issue) begin
        r_pc     <= r_pc + 32'd4;
        r_req_pc <= r_pc;
      end
    end
  end

  // Instruction buffer: two entries with wrapping pointers, flushed on redirect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_mem_data[0] <= 32'h0000_0000;
      r_mem_data[1] <= 32'h0000_0000;
      r_mem_pc[0]   <= 32'h0000_0000;
      r_mem_pc[1]   <= 32'h0000_0000;
    end else if (bus.redirect_valid_i) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= bus.sram_data_i;
        r_mem_pc[r_wr_ptr]   <= r_req_pc;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
    end
  end

  ifu_fetch_chk #(.FIFO_DEPTH(FIFO_DEPTH)) u_chk (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_count (r_count)
  );
endmodule
